// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide scheduler.
//   - md_op_e      : op encodings (mult, multu, div, divu)
//   - md_state_e   : scheduler FSM state encoding (IDLE / RUN)
//   - *_CYC_DEF    : default busy-cycle counts for multiply and divide
//   - op_is_div()  : helper that classifies an op as a division
package md_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // The upper op bit separates divide (1) from multiply (0).
  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_core.sv
// md_core: purely combinational arithmetic for the multiply/divide unit.
// Ports:
//   op      in  2  : md_op_e encoding (bit0 = 1 means unsigned)
//   rs_val  in  32 : multiplicand / dividend
//   rt_val  in  32 : multiplier / divisor
//   res_hi  out 32 : product[63:32] or remainder
//   res_lo  out 32 : product[31:0]  or quotient
//   rt_zero out 1  : divisor is zero (caller decides what that means)
module md_core
  import md_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        rt_zero
);

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] prod;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & rs_val[31];
    b_neg     = is_signed & rt_val[31];

    // Divide on magnitudes so the most-negative dividend cannot overflow,
    // then restore signs: quotient truncates toward zero, remainder follows
    // the dividend.
    a_mag  = a_neg ? (~rs_val + 32'd1) : rs_val;
    b_mag  = b_neg ? (~rt_val + 32'd1) : rt_val;
    // A zero divisor never commits; substitute 1 to keep the divider defined.
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq     = a_mag / b_safe;
    ur     = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    rem    = a_neg ? (~ur + 32'd1) : ur;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned operands.
    a64  = {{32{a_neg}}, rs_val};
    b64  = {{32{b_neg}}, rt_val};
    prod = a64 * b64;

    if (op_is_div(md_op_e'(op))) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
    rt_zero = (rt_val == 32'd0);
  end

endmodule

// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide scheduler with fixed-latency busy window.
// Ports:
//   clk, reset (sync, active-low)
//   start, op, rs_val, rt_val : issue of mult/multu/div/divu
//   mt_en, mt_hi              : mthi/mtlo write of rs_val (idle only)
//   md_use, rd_hi             : decode-stage HI/LO use and read select
//   busy                      : 1 while the FSM is in RUN (FSM state view)
//   stall                     : md_use & (busy | start)
//   hi, lo, rd_data           : committed HI/LO and the selected one
// Handshake: start/mt_en are single-cycle strobes accepted only in IDLE;
// there is no back-pressure, callers watch busy/stall instead.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mt_en,
  input  logic        mt_hi,
  input  logic        md_use,
  input  logic        rd_hi,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  md_op_e            sh_op_q, sh_op_d;
  logic [31:0]       sh_hi_q, sh_hi_d;
  logic [31:0]       sh_lo_q, sh_lo_d;
  logic              sh_rtz_q, sh_rtz_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic [31:0]       core_hi;
  logic [31:0]       core_lo;
  logic              core_rt_zero;

  md_core u_core (
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .res_hi  (core_hi),
    .res_lo  (core_lo),
    .rt_zero (core_rt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_op_d  = sh_op_q;
    sh_hi_d  = sh_hi_q;
    sh_lo_d  = sh_lo_q;
    sh_rtz_d = sh_rtz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        // start outranks mt_en when both arrive together.
        if (start) begin
          sh_op_d  = md_op_e'(op);
          sh_hi_d  = core_hi;
          sh_lo_d  = core_lo;
          sh_rtz_d = core_rt_zero;
          cnt_d    = op_is_div(md_op_e'(op)) ? CNT_W'(DIV_CYC - 1)
                                             : CNT_W'(MULT_CYC - 1);
          state_d  = ST_RUN;
        end else if (mt_en) begin
          if (mt_hi) hi_d = rs_val;
          else       lo_d = rs_val;
        end
      end
      ST_RUN: begin
        // start/mt_en are deliberately not looked at here.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          // Divide by zero burns its cycles but leaves HI/LO alone.
          if (!(op_is_div(sh_op_q) && sh_rtz_q)) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_op_q  <= OP_MULT;
      sh_hi_q  <= '0;
      sh_lo_q  <= '0;
      sh_rtz_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_op_q  <= sh_op_d;
      sh_hi_q  <= sh_hi_d;
      sh_lo_q  <= sh_lo_d;
      sh_rtz_q <= sh_rtz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign stall   = md_use & (busy | start);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: scoreboard bench for md_sched. The driver applies one input
// vector per cycle, advances a behavioural model (remaining-busy counter,
// pending result, arithmetic done in 64-bit longint) and pushes the expected
// post-edge {busy, hi, lo} into exp_q; a monitor pops and compares after
// every rising edge. Combinational stall/rd_data are checked by the driver.
module tb_md_sched;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        mt_en = 1'b0;
  logic        mt_hi = 1'b0;
  logic        md_use = 1'b0;
  logic        rd_hi = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  md_sched #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mt_en   (mt_en),
    .mt_hi   (mt_hi),
    .md_use  (md_use),
    .rd_hi   (rd_hi),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  bit          p_wr = 1'b0;
  int          m_left = 0;   // busy cycles still to come after the current edge

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b @%0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an operation, straight from the arithmetic rules.
  task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin p = {32'h0, a} * {32'h0, b}; rh = p[63:32]; rl = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) wr = 1'b0;
        else begin rl = a / b; rh = a % b; end
      end
    endcase
  endtask

  // Monitor: compare DUT state just after each rising edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk1("busy", busy, e.busy);
      chk32("hi", hi, e.hi);
      chk32("lo", lo, e.lo);
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input bit rn, input bit st, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit mt, input bit mh, input bit mu, input bit rh);
    exp_t        e;
    logic [31:0] rrh, rrl;
    bit          rwr;
    @(negedge clk);
    reset = rn; start = st; op = o; rs_val = a; rt_val = b;
    mt_en = mt; mt_hi = mh; md_use = mu; rd_hi = rh;
    #1;
    chk1("stall", stall, mu & ((m_left > 0) | st));
    chk32("rd_data", rd_data, rh ? m_hi : m_lo);
    // Model of what the next rising edge does.
    if (!rn) begin
      m_hi = '0; m_lo = '0; m_left = 0; p_wr = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (st) begin
      ref_op(o, a, b, rrh, rrl, rwr);
      p_hi = rrh; p_lo = rrl; p_wr = rwr;
      m_left = o[1] ? DC : MC;
    end else if (mt) begin
      if (mh) m_hi = a;
      else    m_lo = a;
    end
    e.busy = (m_left > 0);
    e.hi   = m_hi;
    e.lo   = m_lo;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit mu = 1'b0, input bit rh = 1'b0);
    for (int i = 0; i < n; i++) cycle(1, 0, 2'b00, '0, '0, 0, 0, mu, rh);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit mu = 1'b0);
    cycle(1, 1, o, a, b, 0, 0, mu, 0);
  endtask

  task automatic mtx(input bit mh, input logic [31:0] a);
    cycle(1, 0, 2'b00, a, '0, 1, mh, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] ra, rb;
    // reset
    cycle(0, 0, 2'b00, '0, '0, 0, 0, 0, 0);
    cycle(0, 1, 2'b00, 32'h5, 32'h7, 1, 1, 1, 0);  // reset beats start/mt_en
    idle(1);

    // mult -2 * 3
    issue(2'b00, 32'hFFFF_FFFE, 32'd3);
    idle(MC + 1);
    chk32("mult_hi", hi, 32'hFFFF_FFFF);
    chk32("mult_lo", lo, 32'hFFFF_FFFA);

    // divu 7 / 2, div -7 / 2
    issue(2'b11, 32'd7, 32'd2);
    idle(DC + 1);
    chk32("divu_lo", lo, 32'd3);
    chk32("divu_hi", hi, 32'd1);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    idle(DC + 1);
    chk32("div_lo", lo, 32'hFFFF_FFFD);
    chk32("div_hi", hi, 32'hFFFF_FFFF);

    // mthi then read one cycle later
    mtx(1, 32'h1234);
    cycle(1, 0, 2'b00, '0, '0, 0, 0, 1, 1);
    chk1("mthi_stall", stall, 1'b0);
    chk32("mthi_rd", rd_data, 32'h1234);

    // stall held across a running multu
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, 1);
    for (int i = 0; i < MC; i++) begin
      cycle(1, 0, 2'b00, '0, '0, 0, 0, 1, 0);
      chk1("multu_stall", stall, 1'b1);
    end
    cycle(1, 0, 2'b00, '0, '0, 0, 0, 1, 0);
    chk1("multu_stall_end", stall, 1'b0);
    chk32("multu_hi", hi, 32'h0000_0001);

    // divide by zero keeps LO
    mtx(0, 32'h55);
    issue(2'b10, 32'd100, 32'd0);
    idle(DC + 1);
    chk32("divz_lo", lo, 32'h55);

    // reset in busy cycle 3 of a mult aborts it
    mtx(1, 32'hDEAD);
    mtx(0, 32'hBEEF);
    issue(2'b00, 32'd5, 32'd6);
    idle(2);
    cycle(0, 0, 2'b00, '0, '0, 0, 0, 0, 0);
    idle(1);
    chk1("abort_busy", busy, 1'b0);
    chk32("abort_hi", hi, 32'h0);
    chk32("abort_lo", lo, 32'h0);
    idle(MC + 3);
    chk32("abort_late_lo", lo, 32'h0);

    // start + mt_en while busy are ignored; commit exactly at E0+N
    mtx(0, 32'hAAAA);
    issue(2'b00, 32'd3, 32'd4);
    cycle(1, 1, 2'b11, 32'd9, 32'd2, 1, 0, 0, 0);
    cycle(1, 0, 2'b00, 32'h77, '0, 1, 1, 0, 0);
    idle(MC - 2);
    chk32("busy_ign_lo_pre", lo, 32'hAAAA);
    idle(1);
    chk32("busy_ign_lo", lo, 32'd12);
    chk32("busy_ign_hi", hi, 32'd0);
    idle(DC);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9))  : $urandom();
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 15) == 0) ra = ~ra + 32'd1;
      cycle(($urandom_range(0, 60) != 0), ($urandom_range(0, 5) == 0),
            2'($urandom_range(0, 3)), ra, rb, ($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    idle(DC + 2);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 Parameter MULT_CYC, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYC, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  E-stage mult/multu/div/divu issue strobe.
REQ-006 op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-007 rs_val  input  32  operand A (dividend / multiplicand; mthi/mtlo source).
REQ-008 rt_val  input  32  operand B (divisor / multiplier).
REQ-009 mt_en  input  1  mthi/mtlo write strobe.
REQ-010 mt_hi  input  1  1 = mthi, 0 = mtlo.
REQ-011 md_use  input  1  D-stage instruction is any HI/LO-class instruction.
REQ-012 rd_hi  input  1  read select: 1 = HI, 0 = LO.
REQ-013 busy  output  1  unit is computing.
REQ-014 stall  output  1  pipeline stall request.
REQ-015 hi  output  32  HI register.
REQ-016 lo  output  32  LO register.
REQ-017 rd_data  output  32  HI when rd_hi = 1, otherwise LO; combinational.

Function
REQ-018 The state machine SHALL have two states: IDLE and RUN.
REQ-019 In IDLE, a start sampled at edge E0 SHALL latch the op and computed result into shadow registers, load cnt = N-1 (N = MULT_CYC or DIV_CYC), and enter RUN.
REQ-020 In RUN, cnt SHALL decrement each edge; the edge at which cnt == 0 SHALL commit shadow to HI/LO and return to IDLE.
REQ-021 busy SHALL be 1 exactly in RUN, i.e. N cycles after E0; HI/LO SHALL change at edge E0+N, the same edge busy falls.
REQ-022 mult SHALL be signed and multu unsigned, with {hi,lo} = 64-bit product.
REQ-023 div/divu (signed/unsigned) SHALL give lo = quotient and hi = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-024 Divide by zero (rt_val == 0) SHALL still run DIV_CYC cycles and SHALL leave HI/LO unchanged at commit.
REQ-025 mt_en in IDLE without start SHALL write rs_val to HI (mt_hi = 1) or LO at the next edge, with no busy.
REQ-026 start and mt_en in the same IDLE cycle: start SHALL win and mt_en SHALL be ignored.
REQ-027 start or mt_en while busy SHALL be ignored; cnt, shadow and HI/LO SHALL be unaffected.
REQ-028 stall SHALL equal md_use & (busy | start), combinationally.
REQ-029 rd_data SHALL reflect committed HI/LO only, never shadow values.

Reset
REQ-030 reset == 0 at an edge SHALL force IDLE, cnt = 0, hi = 0, lo = 0 and shadows = 0, giving busy = 0 and stall = 0.
REQ-031 Reset during RUN SHALL abort the operation; no commit SHALL occur.
REQ-032 Reset SHALL take priority over start and mt_en in the same cycle.

Structure
REQ-033 Package md_pkg SHALL hold the op encodings, default MULT_CYC/DIV_CYC, and the IDLE/RUN state encoding.
REQ-034 A combinational sub-module md_core SHALL compute the 64-bit product and the quotient/remainder from op, rs_val and rt_val; md_sched instantiates it once.

Verification
REQ-035 mult rs = 0xFFFFFFFE (-2), rt = 3 -> busy 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
REQ-036 divu rs = 7, rt = 2 -> busy 10 cycles; then lo = 3, hi = 1. div rs = -7, rt = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-037 mthi rs = 0x1234, then 1 cycle later md_use = 1, rd_hi = 1 -> stall = 0, rd_data = 0x1234. During a running multu, md_use = 1 -> stall = 1 for all busy cycles.
REQ-038 div with rt = 0 after mtlo 0x55 -> busy 10 cycles; lo stays 0x55.
REQ-039 reset = 0 at busy cycle 3 of a mult -> next cycle busy = 0, hi = lo = 0; no later commit.
REQ-040 start with a second start and mt_en issued while busy -> only the first operation commits, at exactly E0+N; HI/LO are otherwise untouched.
